// File: rtl/ccd_edge_encoder.sv
// ccd_edge_encoder: encodes each binarised CCD line as START/EDGE/END words into a valid/ready FIFO
module ccd_edge_encoder #(
  parameter int PIX_W      = 11,
  parameter int NUM_PIX    = 2048,
  parameter int MIN_RUN    = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          data_in,
  input  logic                          ccd_pulse,
  input  logic                          sh_pulse_fall,
  input  logic                          sh_pulse_rise,
  output logic [PIX_W+2:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          line_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PIX_W:0]   LAST     = (PIX_W+1)'(NUM_PIX - 1);
  localparam logic [3:0]       RUN_LAST = 4'(MIN_RUN - 1);
  localparam logic [PIX_W-1:0] OFS      = PIX_W'(MIN_RUN - 1);
  localparam logic [AW:0]      FULL     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
  state_t r_state, w_next;

  logic [PIX_W:0]   r_pix_idx;
  logic [3:0]       r_run_cnt;
  logic             r_cur_lvl, r_first_pix, r_overflow;
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic [PIX_W+2:0] r_mem [FIFO_DEPTH];

  logic w_start, w_strobe, w_diff, w_accept, w_emit, w_end, w_pop, w_room, w_push;
  logic [PIX_W-1:0] w_edge_idx;
  logic [PIX_W+2:0] w_word;

  assign w_start    = (r_state == IDLE) & enable & sh_pulse_fall;
  assign w_strobe   = (r_state == READ) & enable & ccd_pulse;
  assign w_diff     = data_in != r_cur_lvl;
  assign w_accept   = !r_first_pix & w_diff & (r_run_cnt == RUN_LAST);
  assign w_emit     = w_strobe & (r_first_pix | w_accept);
  assign w_end      = (r_state == FLUSH) & enable;
  assign w_pop      = out_valid & out_ready;
  assign w_room     = (r_cnt != FULL) | w_pop;
  assign w_push     = (w_emit | w_end) & w_room;
  // EDGE reports the first pixel of the accepted run, not the pixel that confirmed it
  assign w_edge_idx = r_pix_idx[PIX_W-1:0] - OFS;
  assign w_word     = w_end       ? {2'b10, r_overflow, r_pix_idx[PIX_W-1:0]} :
                      r_first_pix ? {2'b01, data_in, {PIX_W{1'b0}}} :
                                    {2'b00, data_in, w_edge_idx};

  always_comb begin
    w_next = r_state;
    if (!enable) w_next = IDLE;
    else if (r_state == IDLE) w_next = sh_pulse_fall ? READ : IDLE;
    else if (r_state == READ) w_next = (sh_pulse_rise | (ccd_pulse & (r_pix_idx == LAST))) ? FLUSH : READ;
    else w_next = w_room ? IDLE : FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pix_idx   <= '0;
      r_run_cnt   <= '0;
      r_cur_lvl   <= 1'b0;
      r_first_pix <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_pix_idx   <= '0;
        r_run_cnt   <= '0;
        r_overflow  <= 1'b0;
        r_first_pix <= 1'b1;
      end else if (w_strobe) begin
        r_pix_idx   <= r_pix_idx + (PIX_W+1)'(1);
        r_first_pix <= 1'b0;
        r_run_cnt   <= (r_first_pix | !w_diff | w_accept) ? '0 : r_run_cnt + 4'd1;
        if (w_emit) r_cur_lvl <= data_in;
        if (w_emit & !w_room) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_word;
  end

  assign out_valid  = r_cnt != '0;
  assign out_data   = out_valid ? r_mem[r_rd] : '0;
  assign line_busy  = r_state != IDLE;
  assign overflow   = r_overflow;
  assign fifo_level = r_cnt;
endmodule
